// File: rtl/fifo_pkg.sv
// fifo_pkg: sizing helpers, defaults and RAM word layout shared by the packet FIFO
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 256;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int last_bit(input int width);
    return width;
  endfunction
endpackage

// File: rtl/RAM_2Port.sv
// RAM_2Port: simple dual-port RAM, one write port and one registered read port
module RAM_2Port #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic                     i_Wr_Clk,
  input  logic [$clog2(DEPTH)-1:0] i_Wr_Addr,
  input  logic                     i_Wr_DV,
  input  logic [WIDTH-1:0]         i_Wr_Data,
  input  logic                     i_Rd_Clk,
  input  logic [$clog2(DEPTH)-1:0] i_Rd_Addr,
  input  logic                     i_Rd_En,
  output logic [WIDTH-1:0]         o_Rd_Data
);
  logic [WIDTH-1:0] mem [DEPTH];
  // store the write word
  always_ff @(posedge i_Wr_Clk)
    if (i_Wr_DV) mem[i_Wr_Addr] <= i_Wr_Data;
  // registered read, output holds between requests
  always_ff @(posedge i_Rd_Clk)
    if (i_Rd_En) o_Rd_Data <= mem[i_Rd_Addr];
endmodule

// File: rtl/fifo_packet.sv
// fifo_packet: packet FIFO with commit/drop, overflow discard and optional FWFT read
module fifo_packet
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MAKE_FWFT = 0
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_Wr_DV,
  input  logic [WIDTH-1:0]         i_Wr_Data,
  input  logic                     i_Wr_Last,
  input  logic                     i_Wr_Drop,
  input  logic [$clog2(DEPTH)-1:0] i_AF_Level,
  output logic                     o_AF_Flag,
  output logic                     o_Full,
  output logic                     o_Wr_Overflow,
  input  logic                     i_Rd_En,
  output logic                     o_Rd_DV,
  output logic [WIDTH-1:0]         o_Rd_Data,
  output logic                     o_Rd_Last,
  input  logic [$clog2(DEPTH)-1:0] i_AE_Level,
  output logic                     o_AE_Flag,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Pkt_Count
);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int LAST_BIT = last_bit(WIDTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam bit FWFT = (MAKE_FWFT != 0);
  logic [ADDR_W-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [CNT_W-1:0] stored, readable, pkt_len, pkt_cnt, in_flight;
  logic ovf_state, ovf_pulse, s1_v, out_v, out_last;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH:0] ram_q;
  logic last_mem [DEPTH];
  logic accept, commit, ovf_hit, ovf_close, discard, pop, pop_last, ld, fetch;
  assign o_Full = stored == FULL_CNT;
  assign o_AF_Flag = stored >= FULL_CNT - CNT_W'(i_AF_Level);
  assign o_AE_Flag = readable <= CNT_W'(i_AE_Level);
  assign accept = i_Wr_DV & ~o_Full & ~i_Wr_Drop & ~ovf_state;
  assign commit = accept & i_Wr_Last;
  assign ovf_hit = i_Wr_DV & ~i_Wr_Drop & (ovf_state | o_Full);
  assign ovf_close = ovf_hit & i_Wr_Last;
  assign discard = i_Wr_Drop | ovf_close;
  assign pop = i_Rd_En & (FWFT ? out_v : readable != '0);
  // the last flag of a standard-mode pop is not out of the RAM yet, so a shadow copy answers it
  assign pop_last = FWFT ? out_last : last_mem[rd_ptr];
  // committed words already pulled into the prefetch stages
  assign in_flight = CNT_W'(s1_v) + CNT_W'(out_v);
  assign ld = FWFT & s1_v & (~out_v | pop);
  assign fetch = FWFT ? (readable != in_flight) & (~s1_v | ld) : pop;
  assign o_Rd_DV = FWFT ? out_v : s1_v;
  assign o_Rd_Data = FWFT ? out_data : (s1_v ? ram_q[WIDTH-1:0] : '0);
  assign o_Rd_Last = FWFT ? out_last : s1_v & ram_q[LAST_BIT];
  assign o_Empty = FWFT ? ~out_v : readable == '0;
  assign o_Wr_Overflow = ovf_pulse;
  assign o_Pkt_Count = pkt_cnt;
  RAM_2Port #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH)) u_ram (
    .i_Wr_Clk (i_Clk),
    .i_Wr_Addr(wr_ptr),
    .i_Wr_DV  (accept),
    .i_Wr_Data({i_Wr_Last, i_Wr_Data}),
    .i_Rd_Clk (i_Clk),
    .i_Rd_Addr(rd_ptr),
    .i_Rd_En  (fetch),
    .o_Rd_Data(ram_q)
  );
  // shadow of the per-word last flag
  always_ff @(posedge i_Clk)
    if (accept) last_mem[wr_ptr] <= i_Wr_Last;
  // pointers, counters, overflow tracking and read pipeline
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) begin
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
      stored <= '0;
      readable <= '0;
      pkt_len <= '0;
      pkt_cnt <= '0;
      ovf_state <= 1'b0;
      ovf_pulse <= 1'b0;
      s1_v <= 1'b0;
      out_v <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      wr_ptr <= discard ? commit_ptr : wr_ptr + ADDR_W'(accept);
      commit_ptr <= commit ? wr_ptr + 1'b1 : commit_ptr;
      rd_ptr <= rd_ptr + ADDR_W'(fetch);
      stored <= stored + CNT_W'(accept) - CNT_W'(pop) - (discard ? pkt_len : '0);
      readable <= readable + (commit ? pkt_len + 1'b1 : '0) - CNT_W'(pop);
      pkt_len <= (discard | commit) ? '0 : pkt_len + CNT_W'(accept);
      pkt_cnt <= pkt_cnt + CNT_W'(commit) - CNT_W'(pop & pop_last);
      ovf_state <= ~i_Wr_Drop & ~ovf_close & (ovf_state | ovf_hit);
      ovf_pulse <= ovf_close;
      s1_v <= fetch | (FWFT & s1_v & ~ld);
      out_v <= ld | (out_v & ~pop);
      out_data <= ld ? ram_q[WIDTH-1:0] : out_data;
      out_last <= ld ? ram_q[LAST_BIT] : out_last;
    end
  assert property (@(posedge i_Clk) disable iff (!i_Rst_L) (stored >= readable) && (stored <= FULL_CNT));
endmodule
